// File: rtl/spi_reg_slave.sv
`timescale 1ns / 1ps
// SPI responder for the MCU-to-FPGA register link.
// cs/sclk/mosi are oversampled in the sys_clk domain. Byte0 of a frame is {rw, addr[6:0]}.
// Each following byte is data, and the address auto-increments with a 7-bit wrap.
// Register accesses are single-cycle strobes. Read data is returned on miso, MSB first.
module spi_reg_slave #(
  parameter logic        CPOL        = 1'b1,
  parameter logic        CPHA        = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       cs,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  output logic [6:0] reg_addr,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_data,
  output logic       reg_rd_en,
  input  logic [7:0] reg_rd_data,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_prev_q, sclk_prev_q;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_fall, cs_rise, lead_edge, trail_edge, sample_edge, shift_edge;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] rx_byte;
  logic [7:0] tx_q, tx_d;
  logic       rw_q, rw_d;
  logic [6:0] addr_q, addr_d;
  logic       wr_pend_q, wr_pend_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       rd_en_q, rd_en_d;
  logic       rd_load_q, rd_load_d;
  logic       miso_q, miso_d;
  logic       busy_q, busy_d;
  logic       frame_err_q, frame_err_d;

  // Input synchronizers plus one history flop each for edge detection.
  // cs history resets low: a frame already in progress at reset is ignored
  // until cs has been seen high and then low again.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall     = cs_prev_q & ~cs_s;
  assign cs_rise     = ~cs_prev_q & cs_s;
  assign lead_edge   = (sclk_prev_q == CPOL) && (sclk_s != CPOL);
  assign trail_edge  = (sclk_prev_q != CPOL) && (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign rx_byte     = {rx_q, mosi_s};

  // State and datapath registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 7'd0;
      tx_q        <= 8'd0;
      rw_q        <= 1'b0;
      addr_q      <= 7'd0;
      wr_pend_q   <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= 8'd0;
      rd_en_q     <= 1'b0;
      rd_load_q   <= 1'b0;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wr_pend_q   <= wr_pend_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      rd_en_q     <= rd_en_d;
      rd_load_q   <= rd_load_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Frame decode: next state, shift registers and register-bank strobes
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wr_pend_d   = 1'b0;
    wr_en_d     = wr_pend_q;   // strobe one cycle after the byte completes
    wr_data_d   = wr_data_q;
    rd_en_d     = 1'b0;
    rd_load_d   = rd_en_q;     // reg_rd_data is valid the cycle after the strobe
    miso_d      = miso_q;
    busy_d      = busy_q;
    frame_err_d = 1'b0;

    // Post-write increment runs independently so a strobe pending at frame end still lands.
    if (wr_en_q) begin
      addr_d = addr_q + 7'd1;
    end

    // cs deassertion wins over any sclk edge seen in the same cycle.
    if (cs_rise) begin
      frame_err_d = (state_q != StIdle) && (bit_cnt_q != 3'd0);
      state_d     = StIdle;
      bit_cnt_d   = 3'd0;
      rx_d        = 7'd0;
      busy_d      = 1'b0;
      miso_d      = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) begin
            state_d   = StCmd;
            bit_cnt_d = 3'd0;
            rx_d      = 7'd0;
            tx_d      = 8'd0;
            busy_d    = 1'b1;
            miso_d    = 1'b0;
          end
        end
        StCmd: begin
          if (sample_edge) begin
            rx_d      = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rw_d    = rx_byte[7];
              addr_d  = rx_byte[6:0];
              rd_en_d = rx_byte[7];
              state_d = StData;
            end
          end
        end
        StData: begin
          if (shift_edge) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (sample_edge) begin
            rx_d      = rx_byte[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rw_q) begin
                // Prefetch the next register so it is ready before the next shift edge.
                addr_d  = addr_q + 7'd1;
                rd_en_d = 1'b1;
              end else begin
                wr_data_d = rx_byte;
                wr_pend_d = 1'b1;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (rd_load_q) begin
      tx_d = reg_rd_data;
    end
  end

  assign miso        = miso_q;
  assign reg_addr    = addr_q;
  assign reg_wr_en   = wr_en_q & ~sys_rst;
  assign reg_wr_data = wr_data_q;
  assign reg_rd_en   = rd_en_q & ~sys_rst;
  assign busy        = busy_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
`timescale 1ns / 1ps
// Bench for spi_reg_slave: a mode-3 and a mode-0 instance, each backed by a register-bank
// model. Expected strobes, miso bytes and frame errors come from a frame-level reference.
module tb_spi_reg_slave;

  localparam int M0 = 0;  // CPOL=0, CPHA=0 instance
  localparam int M3 = 1;  // CPOL=1, CPHA=1 instance

  logic       sys_clk  = 1'b0;
  logic       sys_rst  = 1'b1;
  logic [1:0] cs_pin   = 2'b11;
  logic [1:0] sclk_pin = 2'b10;  // mode-3 idles high, mode-0 idles low
  logic       mosi     = 1'b0;
  logic       mem_init = 1'b0;

  logic [1:0] miso_w, wr_en_w, rd_en_w, busy_w, ferr_w;
  logic [6:0] addr_w    [2];
  logic [7:0] wr_data_w [2];
  logic [7:0] rd_data_w [2];

  logic [7:0]  mem     [2][128];  // register bank seen by the DUTs
  logic [7:0]  ref_mem [2][128];  // reference contents
  logic [15:0] wr_obs  [$];       // {inst, addr, data}
  logic [7:0]  rd_obs  [$];       // {inst, addr}
  logic [7:0]  frm_data [$];
  int          ferr_cnt [2];
  int          n_bad_strobe = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 sys_clk = ~sys_clk;

  spi_reg_slave #(.CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) u_dut_m3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cs(cs_pin[M3]), .sclk(sclk_pin[M3]), .mosi(mosi),
    .miso(miso_w[M3]), .reg_addr(addr_w[M3]), .reg_wr_en(wr_en_w[M3]),
    .reg_wr_data(wr_data_w[M3]), .reg_rd_en(rd_en_w[M3]), .reg_rd_data(rd_data_w[M3]),
    .busy(busy_w[M3]), .frame_err(ferr_w[M3])
  );

  spi_reg_slave #(.CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) u_dut_m0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cs(cs_pin[M0]), .sclk(sclk_pin[M0]), .mosi(mosi),
    .miso(miso_w[M0]), .reg_addr(addr_w[M0]), .reg_wr_en(wr_en_w[M0]),
    .reg_wr_data(wr_data_w[M0]), .reg_rd_en(rd_en_w[M0]), .reg_rd_data(rd_data_w[M0]),
    .busy(busy_w[M0]), .frame_err(ferr_w[M0])
  );

  // Register bank: writes land on the strobe edge, read data one cycle after reg_rd_en.
  always @(posedge sys_clk) begin
    for (int m = 0; m < 2; m++) begin
      if (mem_init) begin
        for (int n = 0; n < 128; n++) mem[m][n] <= 8'(n);
      end else if (wr_en_w[m]) begin
        mem[m][addr_w[m]] <= wr_data_w[m];
      end
      if (rd_en_w[m]) rd_data_w[m] <= mem[m][addr_w[m]];
    end
  end

  // Strobe and frame_err recorder, sampled mid-cycle.
  always @(negedge sys_clk) begin
    for (int m = 0; m < 2; m++) begin
      if (wr_en_w[m]) wr_obs.push_back({m[0], addr_w[m], wr_data_w[m]});
      if (rd_en_w[m]) rd_obs.push_back({m[0], addr_w[m]});
      if (ferr_w[m]) ferr_cnt[m]++;
      if ((wr_en_w[m] && rd_en_w[m]) || (sys_rst && (wr_en_w[m] || rd_en_w[m])))
        n_bad_strobe++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  task automatic half_period();
    wait_clks($urandom_range(9, 13));
  endtask

  task automatic check_outputs_zero(input string tag);
    @(negedge sys_clk);
    for (int m = 0; m < 2; m++)
      check_eq($sformatf("%s_outs_m%0d", tag, m),
               32'({miso_w[m], addr_w[m], wr_en_w[m], wr_data_w[m], rd_en_w[m], busy_w[m],
                    ferr_w[m]}), 32'd0);
  endtask

  // Master side: shift nbits of b (MSB first) and capture miso on each sample edge.
  task automatic xfer(input int m, input logic [7:0] b, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      if (m == M3) begin
        sclk_pin[m] = 1'b0;
        mosi = b[7-i];
        half_period();
        sclk_pin[m] = 1'b1;
        rx = {rx[6:0], miso_w[m]};
        half_period();
      end else begin
        mosi = b[7-i];
        half_period();
        sclk_pin[m] = 1'b1;
        rx = {rx[6:0], miso_w[m]};
        half_period();
        sclk_pin[m] = 1'b0;
      end
    end
  endtask

  // One frame: cmd byte, frm_data bytes, then part_bits of an abandoned byte.
  task automatic run_frame(input int m, input logic [7:0] cmd, input int part_bits,
                           input string tag);
    logic [7:0]  rx;
    logic [6:0]  a;
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    int          w0, r0, f0, n;
    a  = cmd[6:0];
    n  = frm_data.size();
    w0 = wr_obs.size();
    r0 = rd_obs.size();
    f0 = ferr_cnt[m];
    cs_pin[m] = 1'b0;
    wait_clks(6);
    xfer(m, cmd, 8, rx);
    check_eq({tag, "_busy"}, 32'(busy_w[m]), 32'd1);
    for (int i = 0; i < n; i++) begin
      xfer(m, frm_data[i], 8, rx);
      if (cmd[7]) check_eq($sformatf("%s_miso%0d", tag, i), 32'(rx),
                           32'(ref_mem[m][a + 7'(i)]));
    end
    if (part_bits > 0) xfer(m, 8'($urandom), part_bits, rx);
    half_period();
    cs_pin[m] = 1'b1;
    wait_clks(12);

    if (cmd[7]) begin
      for (int i = 0; i <= n; i++) exp_rd.push_back({1'(m), a + 7'(i)});
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_wr.push_back({1'(m), a + 7'(i), frm_data[i]});
        ref_mem[m][a + 7'(i)] = frm_data[i];
      end
    end

    check_eq({tag, "_nwr"}, 32'(wr_obs.size() - w0), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && w0 + i < wr_obs.size(); i++)
      check_eq($sformatf("%s_wr%0d", tag, i), 32'(wr_obs[w0+i]), 32'(exp_wr[i]));
    check_eq({tag, "_nrd"}, 32'(rd_obs.size() - r0), 32'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && r0 + i < rd_obs.size(); i++)
      check_eq($sformatf("%s_rd%0d", tag, i), 32'(rd_obs[r0+i]), 32'(exp_rd[i]));
    check_eq({tag, "_ferr"}, 32'(ferr_cnt[m] - f0), 32'(part_bits != 0));
    check_eq({tag, "_busy_end"}, 32'(busy_w[m]), 32'd0);
  endtask

  task automatic random_frames(input int m, input int count);
    logic [7:0] cmd;
    int         nb, part;
    for (int k = 0; k < count; k++) begin
      cmd  = 8'($urandom);
      nb   = $urandom_range(0, 3);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      frm_data.delete();
      for (int i = 0; i < nb; i++) frm_data.push_back(8'($urandom));
      run_frame(m, cmd, part, $sformatf("rnd_m%0d_%0d", m, k));
    end
  endtask

  initial begin
    logic [7:0] rx;
    int         w0, r0, f0;
    for (int m = 0; m < 2; m++) begin
      ferr_cnt[m] = 0;
      for (int n = 0; n < 128; n++) ref_mem[m][n] = 8'(n);
    end
    mem_init = 1'b1;
    wait_clks(3);
    check_outputs_zero("rst_hold");
    sys_rst  = 1'b0;
    mem_init = 1'b0;
    wait_clks(10);
    check_outputs_zero("rst_rel");

    frm_data = '{8'hA5};
    run_frame(M3, 8'h05, 0, "wr_m3");
    frm_data = '{8'h3C};
    run_frame(M3, 8'h10, 0, "preset");
    frm_data = '{8'h00};
    run_frame(M3, 8'h90, 0, "rd_m3");
    frm_data = '{8'h00, 8'h00};
    run_frame(M3, 8'hFE, 0, "burst_rd");
    frm_data = '{8'h11, 8'h22, 8'h33};
    run_frame(M3, 8'h7F, 0, "burst_wr");
    frm_data.delete();
    run_frame(M3, 8'h05, 4, "abort");
    frm_data = '{8'hA5};
    run_frame(M3, 8'h05, 0, "after_abort");
    frm_data.delete();
    run_frame(M3, 8'h22, 0, "cmd_only");
    random_frames(M3, 10);

    // Reset in the middle of byte1 of a write with cs held low.
    w0 = wr_obs.size();
    r0 = rd_obs.size();
    f0 = ferr_cnt[M3];
    cs_pin[M3] = 1'b0;
    wait_clks(6);
    xfer(M3, 8'h05, 8, rx);
    xfer(M3, 8'hA5, 4, rx);
    sys_rst = 1'b1;
    wait_clks(1);
    sys_rst = 1'b0;
    check_outputs_zero("rst_mid");
    xfer(M3, 8'h50, 4, rx);
    half_period();
    cs_pin[M3] = 1'b1;
    wait_clks(12);
    check_eq("rst_mid_nwr", 32'(wr_obs.size() - w0), 32'd0);
    check_eq("rst_mid_nrd", 32'(rd_obs.size() - r0), 32'd0);
    check_eq("rst_mid_ferr", 32'(ferr_cnt[M3] - f0), 32'd0);
    check_outputs_zero("rst_after");

    frm_data = '{8'hA5};
    run_frame(M0, 8'h05, 0, "wr_m0");
    random_frames(M0, 5);
    frm_data = '{8'h5A};
    run_frame(M3, 8'h05, 0, "wr_m3_recover");

    check_eq("strobe_rules", 32'(n_bad_strobe), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
- SPI responder that lets the external MCU read and write an FPGA-side 8-bit register file over the team's SPI link.
- Sits at the far end of the link from spi_master and pairs with a register-bank block.
- Oversamples cs/sclk/mosi in the sys_clk domain, decodes a command byte, and issues single-cycle register read/write strobes with burst auto-increment.
- Drives miso with read data, MSB first.

Parameters:
- CPOL, 1'b1: sclk idle level.
- CPHA, 1'b1: 0 = sample on leading edge, 1 = sample on trailing edge.
- SYNC_STAGES, 2: synchronizer depth on cs/sclk/mosi, minimum 2.

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- cs  in  1  chip select, active-low, asynchronous to sys_clk.
- sclk  in  1  SPI clock from master, asynchronous.
- mosi  in  1  master-out data, asynchronous.
- miso  out  1  slave-out data, registered.
- reg_addr  out  7  register address.
- reg_wr_en  out  1  one-cycle write strobe.
- reg_wr_data  out  8  write data, valid when reg_wr_en=1.
- reg_rd_en  out  1  one-cycle read strobe.
- reg_rd_data  in  8  read data, valid exactly 1 sys_clk cycle after reg_rd_en.
- busy  out  1  synchronized cs asserted (frame in progress).
- frame_err  out  1  one-cycle pulse on an aborted or partial frame.

Behaviour:
- Reset: every output is 0, state = IDLE, bit counter = 0, shift registers = 0.
- Synchronization:
  - cs, sclk and mosi each pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized sclk.
  - sample_edge = leading edge if CPHA=0, trailing edge if CPHA=1; shift_edge is the other edge.
  - Leading edge = sclk leaving the CPOL level.
- Timing requirement on the master: sclk high and low phases are each ≥ 8 sys_clk cycles. Faster sclk is out of spec.
- Frame format, MSB first:
  - Byte0 = {rw, addr[6:0]}; rw=1 means read.
  - Byte1..N = data, with the address auto-incrementing by 1 per byte (7-bit wrap, 0x7F -> 0x00).
- State IDLE:
  - Synced cs falling -> CMD; bit counter = 0; busy = 1.
  - CPHA=0: miso is loaded with 0 at cs assertion, since no data is defined during byte0.
- State CMD:
  - Each sample_edge shifts mosi into rx_shift.
  - On the 8th bit: latch rw and reg_addr = rx[6:0], then go to DATA.
  - If rw=1, pulse reg_rd_en in the next cycle, and one cycle later load reg_rd_data into tx_shift.
- State DATA:
  - Each shift_edge drives miso = tx_shift[7] and shifts tx_shift left.
  - For CPHA=0, the first bit of each byte is driven on the trailing edge after the previous byte's 8th sample.
  - Each sample_edge shifts mosi into rx_shift. On every 8th bit:
    - Write (rw=0): reg_wr_data = rx byte, pulse reg_wr_en for 1 cycle with the current reg_addr, then increment reg_addr the cycle after the strobe.
    - Read (rw=1): increment reg_addr, pulse reg_rd_en with the new address, and load tx_shift one cycle later. mosi bits are ignored.
- Latency:
  - Write strobe occurs SYNC_STAGES+2 sys_clk cycles after the 8th sample edge reaches the pin.
  - Read data is in tx_shift within SYNC_STAGES+4 cycles, which is before the next shift_edge given the 8-cycle phase minimum.
- Frame end (synced cs rising, any state):
  - Go to IDLE and set busy = 0, miso = 0.
  - If the bit counter ≠ 0 (a partial byte), or the state is CMD with any bits received, pulse frame_err. The partial byte is discarded and no strobe is issued for it.
  - A completed frame with 0 data bytes (command only) is legal; no frame_err.
- Simultaneous events: if cs deassertion and an sclk edge are detected in the same sys_clk cycle, cs wins and the edge is discarded.
- Reset mid-frame:
  - All state is cleared and the block enters IDLE with busy = 0.
  - If cs is still low after reset, the block waits for cs high then cs low before decoding. The remainder of the current frame is ignored and no strobes are issued.
- reg_wr_en and reg_rd_en are never high in the same cycle, and never high while sys_rst = 1.

Test Plan:
- Write, mode 3: cs low, byte0=0x05, byte1=0xA5, cs high -> exactly one reg_wr_en pulse with reg_addr=0x05 and reg_wr_data=0xA5; frame_err stays 0.
- Read, mode 3: byte0=0x90 (read addr 0x10), register model returns 0x3C one cycle after reg_rd_en -> reg_rd_en pulses with addr 0x10 after bit 8; miso shows 0,0,1,1,1,1,0,0 on the byte1 sample edges.
- Burst write with wrap: byte0=0x7F, data 0x11,0x22,0x33 -> three wr strobes with (addr,data) = (7F,11), (00,22), (01,33).
- Burst read: byte0=0xFE, reading 2 bytes from a model where reg[n] = n -> miso bytes 0x7E, 0x7F; reg_rd_en pulses at addr 0x7E, 0x7F, 0x00 (the last is a prefetch).
- Abort: cs high after byte0=0x05 plus 4 data bits -> no reg_wr_en, one frame_err pulse, busy=0; next full write frame works normally.
- Reset mid-frame, plus mode 0: assert sys_rst for 1 cycle during byte1 of a write with cs held low -> no strobe, all outputs 0. Then a CPOL=0/CPHA=0 instance repeats the write test -> one strobe with addr 0x05, data 0xA5.
